muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit in the EX stage of the five-stage pipeline. It accepts one M-extension operation from ID/EX and computes it over several cycles. While it is busy it raises a stall request, which the pipeline control ORs into the PCWrite/IF_ID_Write/ID_EX hold path. It also accepts the branch-flush kill from that control and aborts on it, so it sits on the requesting side of the stall/flush interface.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- start  in  1  ID/EX holds a valid M-op (opcode OP, funct7=0000001); level, held while stalled
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  32  rs1 value (post-forwarding)
- op_b  in  32  rs2 value (post-forwarding)
- kill  in  1  flush of ID/EX (branch taken); aborts any operation
- stall_req  out  1  hold PC, IF/ID, ID/EX this cycle
- result  out  32  registered result, held until next accepted start
- result_valid  out  1  one-cycle pulse; EX uses result instead of ALU output

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE
  - start=1 and kill=0: latch funct3, op_a, op_b.
    - Multiply → MUL.
    - Divide with op_b=0, or signed op_a=0x80000000 with op_b=0xFFFFFFFF → DONE, result loaded directly.
    - Any other divide → DIV; iteration counter = 0; operand magnitudes loaded (absolute values for DIV/REM).
  - start=0 or kill=1: stay in IDLE.
- MUL
  - One cycle: 64-bit product of sign/zero-extended operands (MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned).
  - Result = low 32 bits (MUL) or high 32 bits (others) → DONE.
- DIV
  - Restoring division, one quotient bit per cycle, 32 cycles (counter 0..31); after counter=31 → DONE.
  - Sign fixup applied on exit:
    - Quotient negated if operand signs differ (DIV).
    - Remainder takes the dividend's sign (REM).
- DONE: result_valid=1 for exactly this cycle → IDLE. start is not sampled in DONE.
- Special cases:
  - x/0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = op_a.
  - Signed overflow (0x80000000 / -1): DIV = 0x80000000; REM = 0.
- stall_req = ~kill & ~rst & ((state==IDLE & start) | state==MUL | state==DIV). It is 0 in DONE, so the instruction retires that cycle.
- kill in any state: next state IDLE, result_valid suppressed, result register unchanged. kill together with start in IDLE starts nothing.
- Reset values: state IDLE, result 0x00000000, result_valid 0, counter 0, stall_req 0.
- Reset mid-operation behaves like kill.

## Timing
Cycle T is the first cycle start=1 in IDLE.
- Multiply:
  - stall_req high in T and T+1.
  - result_valid at T+2.
- Divide, normal case:
  - stall_req high in T..T+32 (33 cycles).
  - DIV state occupies T+1..T+32.
  - result_valid at T+33.
- Divide, special case:
  - stall_req high in T only.
  - result_valid at T+1.
- Back-to-back M-ops: the next start is seen in IDLE no earlier than the cycle after DONE. No result is lost.
- Outputs state, result, and result_valid are registered. stall_req is combinational from start/kill/state, with no other combinational input paths.

## Structure
- Package muldiv_pkg holds:
  - funct3 localparams (F3_MUL … F3_REMU).
  - State enum encoding (2 bits).
  - DIV_CYCLES = 32.
- Sub-module div_core holds:
  - Remainder/quotient shift registers and the iteration counter.
  - Interface: load, dividend, divisor, busy, done.
- The top level holds:
  - The FSM.
  - The multiplier.
  - Special-case detection and sign fixup.

## Test plan
- MUL with op_a=7, op_b=0xFFFFFFFD (−3):
  - stall_req high at T, T+1.
  - result_valid at T+2 with result 0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA (−6), with result_valid exactly at T+33 and stall_req high 33 cycles.
- REM −20/3 → 0xFFFFFFFE (−2).
- DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with result_valid at T+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Kill at DIV counter=10:
  - stall_req=0 in the kill cycle.
  - IDLE next cycle; no result_valid.
  - result keeps its old value.
  - A following MUL 3×4 yields 12 at its T+2.
- Reset asserted mid-DIV:
  - All outputs return to reset values the next cycle.
  - start=1 together with kill=1 in IDLE → no stall_req and no state change.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - funct3 encodings of the eight M-extension operations
//   - FSM state encoding
//   - divider iteration count
//   - small helper for taking operand magnitudes
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // One quotient bit per cycle, so one cycle per result bit.
  localparam int         DIV_CYCLES = 32;
  localparam logic [4:0] DIV_LAST   = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Magnitude of a value when it is to be treated as signed. The most
  // negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] value,
                                            input logic        is_signed);
    return (is_signed && value[31]) ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// ---------------------------------------------------------------------------
// div_core
// Unsigned restoring divider producing one quotient bit per clock. The
// caller hands it operand magnitudes; signs are handled outside.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   i_load       in   capture dividend/divisor and begin iterating
//   i_abort      in   drop the current division (flush)
//   i_dividend   in   32-bit unsigned dividend
//   i_divisor    in   32-bit unsigned divisor (never zero when loaded)
//   o_busy       out  an iteration runs this cycle
//   o_done       out  this cycle's iteration is the last one
//   o_quotient   out  quotient after this cycle's iteration (final when o_done)
//   o_remainder  out  remainder after this cycle's iteration (final when o_done)
// ---------------------------------------------------------------------------
module div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_abort,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic [4:0]  r_count;
  logic        r_busy;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;

  // One restoring step. The quotient register doubles as the dividend shift
  // register: its MSB feeds the partial remainder while the new quotient
  // bit enters at the LSB. The partial remainder is always below the
  // divisor, so 33 bits hold the shifted value without overflow.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_fits     = ~w_diff[32];
  assign w_rem_next = w_fits ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_next = {r_quo[30:0], w_fits};

  assign o_busy      = r_busy;
  assign o_done      = r_busy && (r_count == DIV_LAST);
  assign o_quotient  = w_quo_next;
  assign o_remainder = w_rem_next;

  // Iteration registers. Abort only stops the sequence; the data registers
  // are left alone because nothing reads them while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_count   <= 5'd0;
      r_busy    <= 1'b0;
    end else if (i_abort) begin
      r_count <= 5'd0;
      r_busy  <= 1'b0;
    end else if (i_load) begin
      r_rem     <= 32'd0;
      r_quo     <= i_dividend;
      r_divisor <= i_divisor;
      r_count   <= 5'd0;
      r_busy    <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (o_done) begin
        r_busy  <= 1'b0;
        r_count <= 5'd0;
      end else begin
        r_count <= r_count + 5'd1;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit living in EX. Multiplies take one
// compute cycle, divides take 32, divide-by-zero and signed overflow are
// answered immediately. While computing it requests a pipeline stall; a
// branch flush (kill) or reset abandons the operation without touching
// the result register.
//
// Ports:
//   clk           in   pipeline clock
//   rst           in   synchronous active-high reset
//   start         in   ID/EX holds a valid M-op (level, held while stalled)
//   funct3        in   M-op select (MUL..REMU)
//   op_a          in   rs1 value
//   op_b          in   rs2 value
//   kill          in   flush of ID/EX, aborts any operation
//   stall_req     out  hold PC, IF/ID and ID/EX this cycle
//   result        out  registered result, held until replaced
//   result_valid  out  one-cycle pulse in the DONE cycle
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            stall_req,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_funct3;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_valid;

  logic        w_accept;
  logic        w_load_result;
  logic [31:0] w_result_d;

  // Special-case detection on the incoming operands, so these ops can
  // finish straight out of IDLE.
  logic        w_in_div0;
  logic        w_in_ovf;
  logic        w_in_special;
  logic [31:0] w_special_result;

  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_product;
  logic [31:0] w_mul_result;

  logic        w_div_load;
  logic        w_div_busy;
  logic        w_div_done;
  logic [31:0] w_div_quo;
  logic [31:0] w_div_rem;
  logic        w_neg_quo;
  logic        w_neg_rem;
  logic [31:0] w_div_result;

  assign w_accept = (r_state == ST_IDLE) && start && !kill;

  // funct3[2] marks a divide, funct3[1] a remainder, funct3[0] unsigned.
  assign w_in_div0    = (op_b == 32'd0);
  assign w_in_ovf     = !funct3[0] && (op_a == 32'h8000_0000) && (&op_b);
  assign w_in_special = funct3[2] && (w_in_div0 || w_in_ovf);

  // x/0 gives all ones or the dividend; overflow gives the dividend
  // (0x80000000) as quotient and zero remainder.
  always_comb begin
    w_special_result = 32'd0;
    if (w_in_div0) begin
      w_special_result = funct3[1] ? op_a : 32'hFFFF_FFFF;
    end else begin
      w_special_result = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Multiplier on latched operands. Operands are sign- or zero-extended to
  // 64 bits so a plain 64-bit multiply gives the correct low 64 bits of the
  // product for every signedness mix. rs1 is signed except for MULHU, rs2
  // is signed only for MUL/MULH.
  assign w_mul_a = {{32{(r_funct3 != F3_MULHU) & r_a[31]}}, r_a};
  assign w_mul_b = {{32{~r_funct3[1] & r_b[31]}}, r_b};
  assign w_product    = w_mul_a * w_mul_b;
  assign w_mul_result = (r_funct3 == F3_MUL) ? w_product[31:0] : w_product[63:32];

  // The divider always works on magnitudes; signed ops take absolute values.
  assign w_div_load = w_accept && funct3[2] && !w_in_special;

  div_core u_div_core (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_div_load),
    .i_abort     (kill),
    .i_dividend  (magnitude(op_a, !funct3[0])),
    .i_divisor   (magnitude(op_b, !funct3[0])),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  // Sign fixup on exit: quotient negative when operand signs differ,
  // remainder follows the dividend's sign.
  assign w_neg_quo    = !r_funct3[0] && (r_a[31] ^ r_b[31]);
  assign w_neg_rem    = !r_funct3[0] && r_a[31];
  assign w_div_result = r_funct3[1] ?
                        (w_neg_rem ? (32'd0 - w_div_rem) : w_div_rem) :
                        (w_neg_quo ? (32'd0 - w_div_quo) : w_div_quo);

  // Next-state and result-load logic. Kill overrides everything: back to
  // IDLE and the result register is left as it was.
  always_comb begin
    w_next_state  = r_state;
    w_load_result = 1'b0;
    w_result_d    = r_result;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!funct3[2]) begin
            w_next_state = ST_MUL;
          end else if (w_in_special) begin
            w_next_state  = ST_DONE;
            w_load_result = 1'b1;
            w_result_d    = w_special_result;
          end else begin
            w_next_state = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        w_next_state  = ST_DONE;
        w_load_result = 1'b1;
        w_result_d    = w_mul_result;
      end
      ST_DIV: begin
        if (w_div_done) begin
          w_next_state  = ST_DONE;
          w_load_result = 1'b1;
          w_result_d    = w_div_result;
        end else if (!w_div_busy) begin
          // The divider should never go idle here on its own; recover
          // rather than stall the pipeline forever.
          w_next_state = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (kill) begin
      w_next_state  = ST_IDLE;
      w_load_result = 1'b0;
      w_result_d    = r_result;
    end
  end

  // State, operand latches and registered outputs. result_valid is high
  // exactly for the cycle spent in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_funct3 <= 3'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= (w_next_state == ST_DONE);
      if (w_load_result) begin
        r_result <= w_result_d;
      end
      if (w_accept) begin
        r_funct3 <= funct3;
        r_a      <= op_a;
        r_b      <= op_b;
      end
    end
  end

  // Stall while the op is accepted or computing; DONE lets it retire.
  assign stall_req = !kill && !rst &&
                     (((r_state == ST_IDLE) && start) ||
                      (r_state == ST_MUL) || (r_state == ST_DIV));

  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed testbench for muldiv_unit with hand-computed expected values.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// 2 time units after it.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        kill;
  logic        stall_req;
  logic [31:0] result;
  logic        result_valid;

  int nCompared;
  int nMismatched;

  muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .funct3       (funct3),
    .op_a         (opA),
    .op_b         (opB),
    .kill         (kill),
    .stall_req    (stall_req),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op in cycle T and hold start until result_valid. Returns the
  // cycle offset of result_valid (-1 on timeout), the number of stall cycles
  // and the result seen with the valid pulse.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, output int lat,
                               output int stalls, output logic [31:0] res);
    lat    = -1;
    stalls = 0;
    res    = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start  = 1'b1;
    funct3 = f3;
    opA    = a;
    opB    = b;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (stall_req) stalls++;
      if (result_valid) begin
        lat = c;
        res = result;
        break;
      end
      @(posedge clk); #2;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; kill = 1'b0; funct3 = 3'b000; opA = 32'd7; opB = 32'd9;
    repeat (3) @(posedge clk);
    #2;
    nCompared++;
    if (stall_req !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_stall: got %b want 0", stall_req);
    end
    nCompared++;
    if (result !== 32'd0) begin
      nMismatched++; $display("[TB] FAIL reset_result: got %h want 00000000", result);
    end
    nCompared++;
    if (result_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", result_valid);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_mul;
    int lat, stalls;
    logic [31:0] res;
    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, lat, stalls, res);
    nCompared++;
    if (res !== 32'hFFFF_FFEB) begin
      nMismatched++; $display("[TB] FAIL mul_result: got %h want ffffffeb", res);
    end
    nCompared++;
    if (lat !== 2) begin
      nMismatched++; $display("[TB] FAIL mul_latency: got %0d want 2", lat);
    end
    nCompared++;
    if (stalls !== 2) begin
      nMismatched++; $display("[TB] FAIL mul_stalls: got %0d want 2", stalls);
    end
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, res);
    nCompared++;
    if (res !== 32'hFFFF_FFFE) begin
      nMismatched++; $display("[TB] FAIL mulhu_result: got %h want fffffffe", res);
    end
    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, lat, stalls, res);
    nCompared++;
    if (res !== 32'h4000_0000) begin
      nMismatched++; $display("[TB] FAIL mulh_result: got %h want 40000000", res);
    end
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, res);
    nCompared++;
    if (res !== 32'hFFFF_FFFF) begin
      nMismatched++; $display("[TB] FAIL mulhsu_result: got %h want ffffffff", res);
    end
  endtask

  task automatic test_div;
    int lat, stalls;
    logic [31:0] res;
    applyStimulus(3'b100, 32'hFFFF_FFEC, 32'd3, lat, stalls, res);
    nCompared++;
    if (res !== 32'hFFFF_FFFA) begin
      nMismatched++; $display("[TB] FAIL div_result: got %h want fffffffa", res);
    end
    nCompared++;
    if (lat !== 33) begin
      nMismatched++; $display("[TB] FAIL div_latency: got %0d want 33", lat);
    end
    nCompared++;
    if (stalls !== 33) begin
      nMismatched++; $display("[TB] FAIL div_stalls: got %0d want 33", stalls);
    end
    applyStimulus(3'b110, 32'hFFFF_FFEC, 32'd3, lat, stalls, res);
    nCompared++;
    if (res !== 32'hFFFF_FFFE) begin
      nMismatched++; $display("[TB] FAIL rem_result: got %h want fffffffe", res);
    end
    applyStimulus(3'b101, 32'd100, 32'd7, lat, stalls, res);
    nCompared++;
    if (res !== 32'd14) begin
      nMismatched++; $display("[TB] FAIL divu_result: got %h want 0000000e", res);
    end
    applyStimulus(3'b111, 32'd100, 32'd7, lat, stalls, res);
    nCompared++;
    if (res !== 32'd2) begin
      nMismatched++; $display("[TB] FAIL remu_result: got %h want 00000002", res);
    end
  endtask

  task automatic test_special;
    int lat, stalls;
    logic [31:0] res;
    applyStimulus(3'b101, 32'd5, 32'd0, lat, stalls, res);
    nCompared++;
    if (res !== 32'hFFFF_FFFF) begin
      nMismatched++; $display("[TB] FAIL divu_by0_result: got %h want ffffffff", res);
    end
    nCompared++;
    if (lat !== 1) begin
      nMismatched++; $display("[TB] FAIL divu_by0_latency: got %0d want 1", lat);
    end
    nCompared++;
    if (stalls !== 1) begin
      nMismatched++; $display("[TB] FAIL divu_by0_stalls: got %0d want 1", stalls);
    end
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls, res);
    nCompared++;
    if (res !== 32'h8000_0000 || lat !== 1) begin
      nMismatched++; $display("[TB] FAIL div_ovf: got %h at %0d want 80000000 at 1", res, lat);
    end
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls, res);
    nCompared++;
    if (res !== 32'd0 || lat !== 1) begin
      nMismatched++; $display("[TB] FAIL rem_ovf: got %h at %0d want 00000000 at 1", res, lat);
    end
    applyStimulus(3'b111, 32'd5, 32'd0, lat, stalls, res);
    nCompared++;
    if (res !== 32'd5 || lat !== 1) begin
      nMismatched++; $display("[TB] FAIL remu_by0: got %h at %0d want 00000005 at 1", res, lat);
    end
  endtask

  // Result register holds 5 from the last special case on entry.
  task automatic test_kill;
    int lat, stalls, sawValid;
    logic [31:0] res;
    sawValid = 0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b101; opA = 32'd100; opB = 32'd7;
    repeat (11) begin
      @(posedge clk);
      #2;
      if (result_valid) sawValid++;
    end
    nCompared++;
    if (stall_req !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL kill_prestall: got %b want 1", stall_req);
    end
    kill = 1'b1;
    #1;
    nCompared++;
    if (stall_req !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL kill_stall: got %b want 0", stall_req);
    end
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (result_valid) sawValid++;
      @(posedge clk);
    end
    #2;
    nCompared++;
    if (sawValid !== 0) begin
      nMismatched++; $display("[TB] FAIL kill_valid: got %0d pulses want 0", sawValid);
    end
    nCompared++;
    if (result !== 32'd5) begin
      nMismatched++; $display("[TB] FAIL kill_result_held: got %h want 00000005", result);
    end
    applyStimulus(3'b000, 32'd3, 32'd4, lat, stalls, res);
    nCompared++;
    if (res !== 32'd12 || lat !== 2) begin
      nMismatched++; $display("[TB] FAIL kill_then_mul: got %h at %0d want 0000000c at 2", res, lat);
    end
  endtask

  // Result register holds 12 on entry.
  task automatic test_reset_mid_div;
    int sawValid;
    sawValid = 0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b101; opA = 32'd100; opB = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    nCompared++;
    if (stall_req !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL rstmid_stall_in_reset: got %b want 0", stall_req);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    #1;
    nCompared++;
    if (result !== 32'd0 || result_valid !== 1'b0 || stall_req !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_outputs: got res=%h vld=%b stl=%b want 00000000/0/0",
               result, result_valid, stall_req);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (result_valid) sawValid++;
    end
    nCompared++;
    if (sawValid !== 0) begin
      nMismatched++; $display("[TB] FAIL rstmid_valid: got %0d pulses want 0", sawValid);
    end
  endtask

  task automatic test_kill_with_start;
    int sawValid;
    sawValid = 0;
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; opA = 32'd3; opB = 32'd4;
    #1;
    nCompared++;
    if (stall_req !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL killstart_stall: got %b want 0", stall_req);
    end
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (result_valid) sawValid++;
      @(posedge clk);
    end
    #2;
    nCompared++;
    if (sawValid !== 0 || result !== 32'd0) begin
      nMismatched++;
      $display("[TB] FAIL killstart_nostart: got %0d pulses res=%h want 0 pulses 00000000",
               sawValid, result);
    end
  endtask

  task automatic checkOutput;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000; opA = 32'd0; opB = 32'd0;
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_kill;
    test_reset_mid_div;
    test_kill_with_start;
    checkOutput;
    $finish;
  end

  // Hard time limit so the bench always reaches its summary.
  initial begin
    #200000;
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL timeout: simulation did not complete within 200000 time units");
    checkOutput;
    $finish;
  end

endmodule
